// File: rtl/bd_io_pkg.sv
// Shared types and constants for the BD-side asynchronous handshakers.
package bd_io_pkg;

    localparam int unsigned BD_NBDDATA    = 21;
    localparam int unsigned BD_NTIMEOUT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } bd_hs_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset, parameterizable width.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bd_out_handshaker.sv
// Synchronous valid/accept channel to asynchronous 4-phase bundled-data output,
// with programmable data setup, stuck-ack detection and a delivered-word counter.
module bd_out_handshaker
    import bd_io_pkg::*;
#(
    parameter int unsigned NBDdata    = BD_NBDDATA,
    parameter int unsigned Nsetup     = 2,
    parameter int unsigned Ntimeout_w = BD_NTIMEOUT_W,
    parameter int unsigned Ncount     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NBDdata-1:0] in_d,
    input  logic               in_v,
    output logic               in_a,
    output logic [NBDdata-1:0] bd_data,
    output logic               bd_req,
    input  logic               bd_ack,
    input  logic               timeout_clr,
    output logic               timeout,
    output logic [Ncount-1:0]  words_sent
);

    localparam int unsigned SetupW = (Nsetup > 1) ? $clog2(Nsetup) : 1;

    bd_hs_state_t            state_q, state_d;
    logic [SetupW-1:0]       setup_q, setup_d;
    logic [Ntimeout_w-1:0]   to_cnt_q, to_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [Ncount-1:0]       sent_q, sent_d;
    logic [NBDdata-1:0]      data_q, data_d;
    logic                    req_q;
    logic [1:0]              sync_q;
    logic                    ack_s;
    logic                    primed;
    logic                    accept;
    logic                    in_req_q, in_req_d;
    logic                    to_set;

    // Bit 1 is a constant-one pipe: the synchronizer output is not trusted until it
    // has sampled bd_ack twice after reset, so a still-high ack is never missed.
    sync_2ff #(
        .Width (2)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({1'b1, bd_ack}),
        .q     (sync_q)
    );

    assign ack_s  = sync_q[0];
    assign primed = sync_q[1];

    always_comb begin
        state_d = state_q;
        setup_d = setup_q;
        data_d  = data_q;
        sent_d  = sent_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = ~ack_s & primed;
                if (in_v && accept) begin
                    data_d  = in_d;
                    setup_d = SetupW'(Nsetup - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (setup_q == '0) begin
                    state_d = REQ_HI;
                end else begin
                    setup_d = setup_q - SetupW'(1);
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    sent_d  = sent_q + Ncount'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_req_q = (state_q == REQ_HI) || (state_q == REQ_LO);
    assign in_req_d = (state_d == REQ_HI) || (state_d == REQ_LO);

    // Timeout fires once, on the cycle the counter reaches all-ones; a later clear sticks.
    always_comb begin
        to_cnt_d = to_cnt_q;
        to_set   = 1'b0;
        if (in_req_d && (state_d != state_q)) begin
            to_cnt_d = '0;
        end else if (in_req_q) begin
            if (to_cnt_q != '1) begin
                to_cnt_d = to_cnt_q + Ntimeout_w'(1);
                to_set   = (to_cnt_d == '1);
            end
        end
        if (to_set) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            setup_q   <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            sent_q    <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            setup_q   <= setup_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            sent_q    <= sent_d;
            data_q    <= data_d;
            req_q     <= (state_d == REQ_HI);
        end
    end

    assign in_a       = accept;
    assign bd_data    = data_q;
    assign bd_req     = req_q;
    assign timeout    = timeout_q;
    assign words_sent = sent_q;

endmodule

// File: tb/tb_bd_out_handshaker.sv
// Randomized scoreboard bench for bd_out_handshaker with a behavioural chip model.
module tb_bd_out_handshaker;

    localparam int NSETUP = 2;
    localparam int NTO    = 4;
    localparam int NBD    = 21;
    localparam int PERIOD = 7 + NSETUP;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NBD-1:0] in_d = '0;
    logic           in_v = 1'b0;
    logic           in_a;
    logic [NBD-1:0] bd_data;
    logic           bd_req;
    logic           bd_ack;
    logic           timeout_clr = 1'b0;
    logic           timeout;
    logic [31:0]    words_sent;

    logic           w_in_a, w_bd_req, w_timeout;
    logic [NBD-1:0] w_bd_data;
    logic [3:0]     w_words_sent;

    logic chip_ack  = 1'b0;
    logic force_ack = 1'b0;
    logic ack_sel   = 1'b0;
    bit   chip_dly  = 1'b0;
    bit   b2b       = 1'b0;

    assign bd_ack = ack_sel ? force_ack : chip_ack;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [NBD-1:0] exp_q[$];
    int             exp_sent = 0;

    bd_out_handshaker #(
        .NBDdata(NBD), .Nsetup(NSETUP), .Ntimeout_w(NTO), .Ncount(32)
    ) dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
        .bd_data(bd_data), .bd_req(bd_req), .bd_ack(bd_ack),
        .timeout_clr(timeout_clr), .timeout(timeout), .words_sent(words_sent)
    );

    bd_out_handshaker #(
        .NBDdata(NBD), .Nsetup(NSETUP), .Ntimeout_w(NTO), .Ncount(4)
    ) dut_w (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(w_in_a),
        .bd_data(w_bd_data), .bd_req(w_bd_req), .bd_ack(bd_ack),
        .timeout_clr(timeout_clr), .timeout(w_timeout), .words_sent(w_words_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Chip: mirrors bd_req onto bd_ack, optionally after a random delay per phase.
    always begin : chip
        int d;
        @(negedge clk);
        if (!reset && !ack_sel && (bd_req !== chip_ack)) begin
            d = chip_dly ? int'($urandom_range(0, 20)) : 0;
            repeat (d) @(negedge clk);
            chip_ack = bd_req;
        end
    end

    // Monitor: pops the scoreboard on each request rise and checks data hold.
    always begin : monitor
        logic           prev_req;
        logic [NBD-1:0] held;
        logic [NBD-1:0] w;
        bit             active;
        int             last_rise;
        @(negedge clk);
        if (!b2b) last_rise = -1;
        if (reset) begin
            active   = 1'b0;
            prev_req = 1'b0;
        end else begin
            if (bd_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got %0h expected none", bd_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_order", 64'(bd_data), 64'(w));
                end
                held   = bd_data;
                active = 1'b1;
                if (b2b && last_rise >= 0) chk("b2b_period", 64'(cyc - last_rise), PERIOD);
                last_rise = cyc;
            end else if (active) begin
                chk("data_hold", 64'(bd_data), 64'(held));
            end
            if (active && !bd_req && !bd_ack) active = 1'b0;
            prev_req = bd_req;
        end
    end

    task automatic do_reset();
        in_v        = 1'b0;
        timeout_clr = 1'b0;
        reset       = 1'b1;
        exp_q.delete();
        exp_sent = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Offers a word and returns #1 after the transfer edge with in_v still high.
    task automatic send(input logic [NBD-1:0] w);
        int b;
        in_d = w;
        in_v = 1'b1;
        b    = 0;
        @(negedge clk);
        while (!in_a && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (!in_a) begin
            n_chk++;
            $display("FAIL send_accept: got in_a=0 expected 1 within 300 cycles");
        end else begin
            exp_q.push_back(w);
            exp_sent++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        @(negedge clk);
        while (words_sent != 32'(exp_sent) && b < 600) begin
            @(negedge clk);
            b++;
        end
        chk(name, 64'(words_sent), 64'(exp_sent));
        chk("queue_empty", 64'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int r;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_bd_req", 64'(bd_req), 0);
        chk("rst_bd_data", 64'(bd_data), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_words_sent", 64'(words_sent), 0);
        @(posedge clk); #1;

        // Single word, zero-delay chip: transfer is cycle 0
        send(21'h1ABCDE);
        in_v = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("single_req", 64'(bd_req), 64'((c >= NSETUP + 1) && (c <= NSETUP + 3)));
            chk("single_in_a", 64'(in_a), 64'(c >= PERIOD));
            chk("single_data", 64'(bd_data), 64'h1ABCDE);
            if (c == PERIOD) chk("single_sent", 64'(words_sent), 1);
            @(posedge clk); #1;
        end

        // Random chip delay
        do_reset();
        chip_dly = 1'b1;
        for (int i = 0; i < 12; i++) send(NBD'($urandom()));
        in_v = 1'b0;
        drain("delay_sent");
        chip_dly = 1'b0;

        // Back-to-back
        do_reset();
        b2b = 1'b1;
        for (int i = 0; i < 16; i++) send(NBD'($urandom()));
        in_v = 1'b0;
        drain("b2b_sent");
        b2b = 1'b0;

        // Stuck ack: request rises in cycle r, timeout visible in r + 2^NTO - 1
        do_reset();
        ack_sel   = 1'b1;
        force_ack = 1'b0;
        send(21'h0F0F0F);
        in_v = 1'b0;
        r = 1 + NSETUP;
        for (int c = 1; c <= r + 20; c++) begin
            timeout_clr = (c == r + (1 << NTO) - 2) || (c == r + (1 << NTO) + 1);
            @(negedge clk);
            chk("stuck_req", 64'(bd_req), 64'(c >= r));
            chk("stuck_timeout", 64'(timeout),
                64'((c >= r + (1 << NTO) - 1) && (c <= r + (1 << NTO) + 1)));
            @(posedge clk); #1;
        end
        timeout_clr = 1'b0;

        // Reset during REQ_HI with the chip acknowledging
        force_ack = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        exp_sent = 0;
        #1;
        chk("midrst_req", 64'(bd_req), 0);
        chk("midrst_data", 64'(bd_data), 0);
        chk("midrst_sent", 64'(words_sent), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midrst_in_a_held", 64'(in_a), 0);
            @(posedge clk); #1;
        end
        force_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_in_a_release", 64'(in_a), 64'(k >= 2));
            @(posedge clk); #1;
        end
        ack_sel = 1'b0;

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) send(NBD'($urandom()));
        in_v = 1'b0;
        drain("wrap_sent32");
        chk("wrap_sent4", 64'(w_words_sent), 64'(exp_sent % 16));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
